// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the key schedule and cipher round logic.
//   rk_t        - 128-bit round key in row-major 4x4 byte layout
//                 (bits [127:96] = row 0, bytes s00 s01 s02 s03)
//   AES128_NR   - number of rounds for AES-128
//   key_state_t - key-expansion FSM states
//   SBOX        - forward S-box table
//   RCON        - round constants, indexed by round number (entry 0 unused)
//   col_get/col_put - extract/insert FIPS word w[c] (column c) of a layout key
package aes_pkg;

    typedef logic [127:0] rk_t;

    localparam int AES128_NR = 10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } key_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Padded to 16 entries so a 4-bit round counter indexes it without range issues.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Column c is byte c of each row; shifting left by 8*c brings it to the top byte of each row.
    function automatic logic [31:0] col_get(input rk_t k, input logic [1:0] c);
        rk_t s;
        s = k << {c, 3'b000};
        return {s[127:120], s[95:88], s[63:56], s[31:24]};
    endfunction

    function automatic rk_t col_put(input rk_t k, input logic [1:0] c, input logic [31:0] w);
        rk_t m;
        rk_t v;
        m = {8'hff, 24'h0, 8'hff, 24'h0, 8'hff, 24'h0, 8'hff, 24'h0} >> {c, 3'b000};
        v = {w[31:24], 24'h0, w[23:16], 24'h0, w[15:8], 24'h0, w[7:0], 24'h0} >> {c, 3'b000};
        return (k & ~m) | v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
//   din  - input byte
//   dout - substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes128_key_expand.sv
// aes128_key_expand: iterative AES-128 key schedule, one round key per clock,
// stored in an internal register file and read back by index.
//   clk, reset  - clock, asynchronous active-high reset
//   key_in      - cipher key (row-major layout), sampled on key_load
//   key_load    - strobe: start (or restart) expansion of key_in
//   busy        - high while rk1..rk10 are being computed
//   keys_valid  - high when rk0..rk10 all belong to the last loaded key
//   rk_idx      - round-key read index 0..10 (larger indices read zero)
//   rk_out      - registered round key for rk_idx, one cycle latency
module aes128_key_expand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam logic [3:0] LAST_RC = 4'(NR);

    key_state_t state;
    logic [3:0] rc;
    rk_t        rk [0:AES128_NR];
    // Copy of rk[rc-1]; avoids an 11-way read mux in the expansion path.
    rk_t        cur_key;

    logic [31:0] w0_prev, w1_prev, w2_prev, w3_prev;
    logic [31:0] rot_word, sub_word, temp;
    logic [31:0] w0_next, w1_next, w2_next, w3_next;
    rk_t         next_key;

    assign w0_prev  = col_get(cur_key, 2'd0);
    assign w1_prev  = col_get(cur_key, 2'd1);
    assign w2_prev  = col_get(cur_key, 2'd2);
    assign w3_prev  = col_get(cur_key, 2'd3);
    assign rot_word = {w3_prev[23:0], w3_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_word[8*g +: 8]),
            .dout (sub_word[8*g +: 8])
        );
    end

    assign temp    = sub_word ^ {RCON[rc], 24'h0};
    assign w0_next = w0_prev ^ temp;
    assign w1_next = w1_prev ^ w0_next;
    assign w2_next = w2_prev ^ w1_next;
    assign w3_next = w3_prev ^ w2_next;

    always_comb begin
        next_key = '0;
        next_key = col_put(next_key, 2'd0, w0_next);
        next_key = col_put(next_key, 2'd1, w1_next);
        next_key = col_put(next_key, 2'd2, w2_next);
        next_key = col_put(next_key, 2'd3, w3_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rc         <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rk_out     <= '0;
            cur_key    <= '0;
            for (int i = 0; i <= AES128_NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            rk_out <= (rk_idx <= LAST_RC) ? rk[rk_idx] : '0;

            // A load wins in either state, discarding any partial expansion.
            if (key_load) begin
                rk[0]      <= key_in;
                cur_key    <= key_in;
                rc         <= 4'd1;
                keys_valid <= 1'b0;
                busy       <= 1'b1;
                state      <= ST_EXPAND;
            end else if (state == ST_EXPAND) begin
                rk[rc]  <= next_key;
                cur_key <= next_key;
                if (rc == LAST_RC) begin
                    rc         <= '0;
                    busy       <= 1'b0;
                    keys_valid <= 1'b1;
                    state      <= ST_IDLE;
                end else begin
                    rc <= rc + 4'd1;
                end
            end
        end
    end

    a_rc_range: assert property (@(posedge clk) disable iff (reset)
        busy |-> (rc >= 4'd1 && rc <= LAST_RC));

endmodule

// File: tb/tb_aes128_key_expand.sv
// tb_aes128_key_expand: self-checking bench for aes128_key_expand.
// The reference key schedule derives its S-box from the GF(2^8) inverse plus
// affine map and its round constants by repeated doubling.
module tb_aes128_key_expand;

    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    aes128_key_expand #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]   tb_sbox [256];
    logic [127:0] ref_rk  [11];

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FIPS_KEY  = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
    localparam logic [127:0] FIPS_KEY2 = 128'h2B28AB097EAEF7CF15D2154F16A6883D;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int c = 0; c < 4; c++)
            w[c] = {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) begin
            logic [127:0] k = '0;
            for (int c = 0; c < 4; c++) begin
                k[127-8*c -: 8] = w[4*j+c][31:24];
                k[95-8*c  -: 8] = w[4*j+c][23:16];
                k[63-8*c  -: 8] = w[4*j+c][15:8];
                k[31-8*c  -: 8] = w[4*j+c][7:0];
            end
            ref_rk[j] = k;
        end
    endtask

    // Issues a load, then counts edges (load edge included) until keys_valid.
    task automatic load_and_wait(input logic [127:0] key, output int n, output bit busy_gap);
        key_in   = key;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        n        = 1;
        busy_gap = 1'b0;
        while (!keys_valid && n < 20) begin
            if (!busy) busy_gap = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic read_all_desc(input string tag);
        rk_idx = 4'd10;
        for (int i = 10; i >= 0; i--) begin
            tick();
            check($sformatf("%s rk%0d", tag, i), rk_out, ref_rk[i]);
            if (i > 0) rk_idx = 4'(i - 1);
        end
    endtask

    initial begin
        vec_t vecs [5];
        int   n;
        bit   gap;

        reset    = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        rk_idx   = 4'd0;
        build_sbox();
        #3;
        check("reset busy", {127'h0, busy}, 128'h0);
        check("reset keys_valid", {127'h0, keys_valid}, 128'h0);
        check("reset rk_out", rk_out, 128'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // FIPS-197 vector
        model_expand(FIPS_KEY);
        load_and_wait(FIPS_KEY, n, gap);
        check("fips latency", 128'(n), 128'd11);
        check("fips busy gap", {127'h0, gap}, 128'h0);
        check("fips busy after", {127'h0, busy}, 128'h0);

        vecs[0] = '{4'd1,  128'hA088232AFA54A36CFE2C397617B13905};
        vecs[1] = '{4'd10, 128'hD0C9E1B614EE3F63F9250C0CA889C8A6};
        vecs[2] = '{4'd0,  FIPS_KEY};
        vecs[3] = '{4'd11, 128'h0};
        vecs[4] = '{4'd15, 128'h0};
        for (int i = 0; i < 5; i++) begin
            rk_idx = vecs[i].idx;
            tick();
            check($sformatf("fips idx%0d", vecs[i].idx), rk_out, vecs[i].exp);
        end
        read_all_desc("fips model");

        // Restart mid-expansion; also checks keys_valid drop after a load in IDLE.
        model_expand(FIPS_KEY2);
        key_in   = FIPS_KEY;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("drop keys_valid", {127'h0, keys_valid}, 128'h0);
        gap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!busy) gap = 1'b1;
            tick();
        end
        if (!busy) gap = 1'b1;
        check("restart busy before", {127'h0, gap}, 128'h0);
        load_and_wait(FIPS_KEY2, n, gap);
        check("restart latency", 128'(n), 128'd11);
        check("restart busy gap", {127'h0, gap}, 128'h0);
        read_all_desc("restart");

        // Reset during round 5
        key_in   = FIPS_KEY;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("midreset busy", {127'h0, busy}, 128'h0);
        check("midreset keys_valid", {127'h0, keys_valid}, 128'h0);
        check("midreset rk_out", rk_out, 128'h0);
        tick();
        reset  = 1'b0;
        rk_idx = 4'd3;
        tick();
        check("midreset rk3 cleared", rk_out, 128'h0);
        rk_idx = 4'd0;
        tick();
        check("midreset rk0 cleared", rk_out, 128'h0);
        model_expand(FIPS_KEY2);
        load_and_wait(FIPS_KEY2, n, gap);
        check("reload latency", 128'(n), 128'd11);
        rk_idx = 4'd10;
        tick();
        check("reload rk10", rk_out, ref_rk[10]);

        // Randomized keys, some preceded by an interrupted decoy load.
        for (int it = 0; it < 1000; it++) begin
            logic [127:0] key;
            key = {$urandom, $urandom, $urandom, $urandom};
            if (it % 8 == 3) begin
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                key_load = 1'b1;
                tick();
                key_load = 1'b0;
                repeat ($urandom_range(1, 9)) tick();
            end
            model_expand(key);
            load_and_wait(key, n, gap);
            check($sformatf("rand%0d latency", it), 128'(n), 128'd11);
            read_all_desc($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key-schedule engine that sits directly upstream of `AES128`. It expands one 128-bit cipher key into the 11 round keys (rk0..rk10), computing one round key per clock, and stores them in an internal register file. The cipher core reads any round key by index: ascending for encryption (`selCypher=1`), descending for decryption (`selCypher=0`). Key expansion then happens once per key, not once per block.

## Interface
Parameters:
- `NR`, default 10, number of rounds; fixed at 10 for AES-128, exposed only for assertions.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_in`  in  128  cipher key, in the codebase state layout (below).
- `key_load`  in  1  single-cycle strobe; samples `key_in` and starts expansion.
- `busy`  out  1  high while round keys 1..10 are being computed.
- `keys_valid`  out  1  high when rk0..rk10 all correspond to the last loaded key.
- `rk_idx`  in  4  round-key read index, 0..10.
- `rk_out`  out  128  registered round key for `rk_idx`, same layout as `key_in`.

## Operation
- Layout is row-major 4x4 bytes. Bits [127:96] hold row 0, bytes s00 s01 s02 s03. FIPS word w[c] is column c, built from bits [127-8c -: 8], [95-8c -: 8], [63-8c -: 8], [31-8c -: 8]. Round keys are stored and returned in the same layout.
- FSM states:
  - IDLE: `busy=0`.
  - EXPAND: `busy=1`, round counter `rc` runs 1..10.
- IDLE + `key_load`:
  - rk[0] <= `key_in`, `rc` <= 1, `keys_valid` <= 0, go to EXPAND.
- EXPAND, each cycle, with rk[rc-1] as the previous key:
  - temp = SubWord(RotWord(w3_prev)) ^ {Rcon[rc],24'h0}
  - w0 = w0_prev ^ temp; w1 = w1_prev ^ w0; w2 = w2_prev ^ w1; w3 = w3_prev ^ w2
  - Write rk[rc], increment `rc`.
  - After writing rk[10]: go to IDLE, `keys_valid` <= 1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- `key_load` during EXPAND restarts the expansion with the new `key_in`. Same actions as from IDLE; the old partial expansion is discarded.
- `key_load` in IDLE while `keys_valid=1`: `keys_valid` drops the cycle after the load edge.
- Reads:
  - `rk_out` <= rk[`rk_idx`] every cycle, regardless of state.
  - `rk_idx` > 10 returns 128'h0.
  - Reads during EXPAND return whatever is currently stored; the consumer must gate on `keys_valid`.
- Reset:
  - `busy`=0, `keys_valid`=0, `rk_out`=0, all rk[]=0, `rc`=0, state IDLE.
  - Reset mid-expansion aborts it with no residue.

## Timing
- Load edge at cycle T writes rk0. rk1..rk10 are written at edges T+1..T+10.
- `busy` is high from after edge T through edge T+10.
- `keys_valid` is high from after edge T+10.
- Total latency from `key_load` to valid is 11 edges. Back-to-back loads are legal.
- Read latency is 1 cycle: `rk_idx` is sampled at edge N and `rk_out` is valid after edge N.
- S-box lookup is combinational: 4 instances used in parallel within one cycle. No multi-cycle paths.

## Structure
- Package `aes_pkg`:
  - S-box constant array (256x8)
  - Rcon array
  - `rk_t` typedef (logic [127:0])
  - constant `AES128_NR=10`
  - state enum
  - layout helpers `col_get`/`col_put`
- Sub-module `aes_sbox` (8-bit in, 8-bit out, combinational, uses the `aes_pkg` table), instantiated 4 times.
- `aes_sbox` is shared with the cipher round logic.

## Test plan
- FIPS-197 key (layout form 128'h2B28AB097EAEF7CF15D2154F16A6883C), one `key_load` -> `keys_valid` rises exactly 11 edges later. Then:
  - `rk_idx`=1 -> `rk_out` = 128'hA088232AFA54A36CFE2C397617B13905
  - `rk_idx`=10 -> `rk_out` = 128'hD0C9E1B614EE3F63F9250C0CA889C8A6
- Same key, `rk_idx`=0 -> `rk_out` equals `key_in`. Then `rk_idx`=11 and `rk_idx`=15 -> `rk_out` = 0.
- Load key ...883C, then load ...883D 4 cycles later (mid-expansion) -> `busy` continuous. `keys_valid` rises 11 edges after the second load. Every rk matches a reference model for ...883D.
- Assert `reset` at round 5 -> all outputs 0 on the same edge. Reload afterwards -> correct rk10 with no stale data.
- Randomized keys, 1000 iterations, checked against a software key-schedule model: all 11 round keys per key. Reads in descending order 10..0 return correct values on consecutive cycles.
